// File: rtl/mips_isa_pkg.sv
// ============================================================================
// Module   : mips_isa_pkg
// Brief    : MIPS opcode/funct tables, loader mnemonics and word-builder helpers
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_isa_pkg;

    // Opcode / funct values mirror the Control decoder tables
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam int ILLEGAL_MIN = 26;

    typedef enum logic [4:0] {
        MN_ADD   = 5'd0,  MN_ADDU  = 5'd1,  MN_SUB   = 5'd2,  MN_SUBU  = 5'd3,
        MN_AND   = 5'd4,  MN_OR    = 5'd5,  MN_XOR   = 5'd6,  MN_NOR   = 5'd7,
        MN_SLL   = 5'd8,  MN_SRL   = 5'd9,  MN_SRA   = 5'd10, MN_SLT   = 5'd11,
        MN_SLTU  = 5'd12, MN_JR    = 5'd13, MN_JALR  = 5'd14, MN_LW    = 5'd15,
        MN_SW    = 5'd16, MN_LUI   = 5'd17, MN_ADDI  = 5'd18, MN_ADDIU = 5'd19,
        MN_ANDI  = 5'd20, MN_SLTI  = 5'd21, MN_SLTIU = 5'd22, MN_BEQ   = 5'd23,
        MN_J     = 5'd24, MN_JAL   = 5'd25
    } mnemonic_e;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SEAL = 2'd1,
        ST_DONE = 2'd2
    } loader_state_e;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_instr_encoder.sv
// ============================================================================
// Module   : mips_instr_encoder
// Brief    : Combinational mnemonic + operand fields -> 32-bit MIPS word
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_instr_encoder
    import mips_isa_pkg::*;
(
    input  logic [4:0]  mnemonic_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    always_comb begin
        word_o  = 32'h0000_0000;
        legal_o = (mnemonic_i < 5'(ILLEGAL_MIN));
        // Fields the instruction does not use are forced to zero
        case (mnemonic_e'(mnemonic_i))
            MN_ADD:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, F_ADD);
            MN_ADDU:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, F_ADDU);
            MN_SUB:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, F_SUB);
            MN_SUBU:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, F_SUBU);
            MN_AND:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, F_AND);
            MN_OR:    word_o = r_word(rs_i, rt_i, rd_i, 5'd0, F_OR);
            MN_XOR:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, F_XOR);
            MN_NOR:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, F_NOR);
            MN_SLL:   word_o = r_word(5'd0, rt_i, rd_i, shamt_i, F_SLL);
            MN_SRL:   word_o = r_word(5'd0, rt_i, rd_i, shamt_i, F_SRL);
            MN_SRA:   word_o = r_word(5'd0, rt_i, rd_i, shamt_i, F_SRA);
            MN_SLT:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, F_SLT);
            MN_SLTU:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, F_SLTU);
            MN_JR:    word_o = r_word(rs_i, 5'd0, 5'd0, 5'd0, F_JR);
            MN_JALR:  word_o = r_word(rs_i, 5'd0, rd_i, 5'd0, F_JALR);
            MN_LW:    word_o = i_word(OP_LW, rs_i, rt_i, imm_i);
            MN_SW:    word_o = i_word(OP_SW, rs_i, rt_i, imm_i);
            MN_LUI:   word_o = i_word(OP_LUI, 5'd0, rt_i, imm_i);
            MN_ADDI:  word_o = i_word(OP_ADDI, rs_i, rt_i, imm_i);
            MN_ADDIU: word_o = i_word(OP_ADDIU, rs_i, rt_i, imm_i);
            MN_ANDI:  word_o = i_word(OP_ANDI, rs_i, rt_i, imm_i);
            MN_SLTI:  word_o = i_word(OP_SLTI, rs_i, rt_i, imm_i);
            MN_SLTIU: word_o = i_word(OP_SLTIU, rs_i, rt_i, imm_i);
            MN_BEQ:   word_o = i_word(OP_BEQ, rs_i, rt_i, imm_i);
            MN_J:     word_o = {OP_J, target_i};
            MN_JAL:   word_o = {OP_JAL, target_i};
            default:  word_o = 32'h0000_0000;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_program_loader.sv
// ============================================================================
// Module   : mips_program_loader
// Brief    : Streams encoded instructions into IMEM, then seals with a self-jump
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_program_loader
    import mips_isa_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [4:0]            Mnemonic,
    input  logic [4:0]            Rs,
    input  logic [4:0]            Rt,
    input  logic [4:0]            Rd,
    input  logic [4:0]            Shamt,
    input  logic [15:0]           Imm,
    input  logic [25:0]           Target,
    input  logic                  SealReq,
    output logic                  IMemWrite,
    output logic [ADDR_WIDTH+1:0] IMemAddr,
    output logic [31:0]           IMemWData,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  Full,
    output logic                  Done,
    output logic                  Error
);

    localparam logic [ADDR_WIDTH-1:0] IDX_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);

    loader_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
    logic [31:0]             data_q, data_d;
    logic                    err_q, err_d;

    logic [31:0]             enc_word;
    logic                    enc_legal;
    logic                    hs;

    mips_instr_encoder u_encoder (
        .mnemonic_i (Mnemonic),
        .rs_i       (Rs),
        .rt_i       (Rt),
        .rd_i       (Rd),
        .shamt_i    (Shamt),
        .imm_i      (Imm),
        .target_i   (Target),
        .word_o     (enc_word),
        .legal_o    (enc_legal)
    );

    assign Full      = (idx_q == IDX_MAX);
    assign InReady   = (state_q == ST_LOAD) && !Full;
    assign hs        = InValid && InReady;
    assign IMemWrite = wr_q;
    assign IMemAddr  = addr_q;
    assign IMemWData = data_q;
    assign Count     = count_q;
    assign Done      = (state_q == ST_DONE);
    assign Error     = err_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_LOAD: begin
                if (hs) begin
                    if (enc_legal) begin
                        wr_d    = 1'b1;
                        addr_d  = {idx_q, 2'b00};
                        data_d  = enc_word;
                        idx_d   = idx_q + IDX_ONE;
                        count_d = count_q + CNT_ONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (SealReq) begin
                    state_d = ST_SEAL;
                end
            end
            ST_SEAL: begin
                // Halt loop: jump to the seal word's own index; idx stays put
                wr_d    = 1'b1;
                addr_d  = {idx_q, 2'b00};
                data_d  = {OP_J, 26'(idx_q)};
                count_d = count_q + CNT_ONE;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
            count_q <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_program_loader.sv
// ============================================================================
// Module   : tb_mips_program_loader
// Brief    : Directed self-checking bench for mips_program_loader (AW=8 and AW=2)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_program_loader;

    localparam logic [4:0] M_ADD  = 5'd0;
    localparam logic [4:0] M_SLL  = 5'd8;
    localparam logic [4:0] M_LW   = 5'd15;
    localparam logic [4:0] M_ADDI = 5'd18;
    localparam logic [4:0] M_BAD  = 5'd27;

    logic        clk;
    logic        reset;
    logic        InValid;
    logic [4:0]  Mnemonic, Rs, Rt, Rd, Shamt;
    logic [15:0] Imm;
    logic [25:0] Target;
    logic        SealReq;

    logic        InReady, IMemWrite, Full, Done, Error;
    logic [9:0]  IMemAddr;
    logic [31:0] IMemWData;
    logic [8:0]  Count;

    logic        s_InReady, s_IMemWrite, s_Full, s_Done, s_Error;
    logic [3:0]  s_IMemAddr;
    logic [31:0] s_IMemWData;
    logic [2:0]  s_Count;

    int n_tests = 0;
    int n_fail  = 0;

    mips_program_loader #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
        .Mnemonic(Mnemonic), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt),
        .Imm(Imm), .Target(Target), .SealReq(SealReq),
        .IMemWrite(IMemWrite), .IMemAddr(IMemAddr), .IMemWData(IMemWData),
        .Count(Count), .Full(Full), .Done(Done), .Error(Error)
    );

    mips_program_loader #(.ADDR_WIDTH(2)) dut_small (
        .clk(clk), .reset(reset), .InValid(InValid), .InReady(s_InReady),
        .Mnemonic(Mnemonic), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt),
        .Imm(Imm), .Target(Target), .SealReq(SealReq),
        .IMemWrite(s_IMemWrite), .IMemAddr(s_IMemAddr), .IMemWData(s_IMemWData),
        .Count(s_Count), .Full(s_Full), .Done(s_Done), .Error(s_Error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm);
        Mnemonic = mn; Rs = rs; Rt = rt; Rd = rd; Shamt = sh; Imm = imm; Target = 26'd0;
    endtask

    task automatic do_reset();
        reset = 1'b0; InValid = 1'b0; SealReq = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; InValid = 1'b0; SealReq = 1'b0;
        set_req(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0);
        do_reset();

        check_eq("rst_wr",    64'(IMemWrite), 64'd0);
        check_eq("rst_addr",  64'(IMemAddr),  64'd0);
        check_eq("rst_data",  64'(IMemWData), 64'd0);
        check_eq("rst_count", 64'(Count),     64'd0);
        check_eq("rst_full",  64'(Full),      64'd0);
        check_eq("rst_done",  64'(Done),      64'd0);
        check_eq("rst_err",   64'(Error),     64'd0);
        check_eq("rst_ready", 64'(InReady),   64'd1);

        // Single ADDI
        set_req(M_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5);
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        check_eq("addi_wr",    64'(IMemWrite), 64'd1);
        check_eq("addi_addr",  64'(IMemAddr),  64'd0);
        check_eq("addi_data",  64'(IMemWData), 64'h20080005);
        check_eq("addi_count", 64'(Count),     64'd1);
        tick();
        check_eq("addi_idle",  64'(IMemWrite), 64'd0);

        // Back-to-back ADD / SLL / LW then seal
        do_reset();
        set_req(M_ADD, 5'd8, 5'd9, 5'd10, 5'd3, 16'd0);
        InValid = 1'b1;
        tick();
        check_eq("add_wr",   64'(IMemWrite), 64'd1);
        check_eq("add_addr", 64'(IMemAddr),  64'd0);
        check_eq("add_data", 64'(IMemWData), 64'h01095020);
        set_req(M_SLL, 5'd7, 5'd3, 5'd2, 5'd4, 16'd0);
        tick();
        check_eq("sll_wr",   64'(IMemWrite), 64'd1);
        check_eq("sll_addr", 64'(IMemAddr),  64'd4);
        check_eq("sll_data", 64'(IMemWData), 64'h00031100);
        set_req(M_LW, 5'd29, 5'd8, 5'd0, 5'd0, 16'd4);
        tick();
        check_eq("lw_wr",    64'(IMemWrite), 64'd1);
        check_eq("lw_addr",  64'(IMemAddr),  64'd8);
        check_eq("lw_data",  64'(IMemWData), 64'h8FA80004);
        check_eq("lw_count", 64'(Count),     64'd3);
        InValid = 1'b0;
        SealReq = 1'b1;
        tick();
        SealReq = 1'b0;
        check_eq("seal_gap_wr", 64'(IMemWrite), 64'd0);
        tick();
        check_eq("seal_wr",    64'(IMemWrite), 64'd1);
        check_eq("seal_addr",  64'(IMemAddr),  64'hC);
        check_eq("seal_data",  64'(IMemWData), 64'h08000003);
        check_eq("seal_count", 64'(Count),     64'd4);
        check_eq("seal_done",  64'(Done),      64'd1);
        check_eq("seal_ready", 64'(InReady),   64'd0);
        set_req(M_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5);
        InValid = 1'b1;
        SealReq = 1'b1;
        tick();
        InValid = 1'b0;
        SealReq = 1'b0;
        check_eq("done_ign_wr",    64'(IMemWrite), 64'd0);
        check_eq("done_ign_count", 64'(Count),     64'd4);

        // Illegal mnemonic, then ADDI lands at same address
        do_reset();
        set_req(M_BAD, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0);
        InValid = 1'b1;
        tick();
        check_eq("bad_wr",    64'(IMemWrite), 64'd0);
        check_eq("bad_err",   64'(Error),     64'd1);
        check_eq("bad_count", 64'(Count),     64'd0);
        set_req(M_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5);
        tick();
        check_eq("post_bad_addr", 64'(IMemAddr),  64'd0);
        check_eq("post_bad_data", 64'(IMemWData), 64'h20080005);
        check_eq("post_bad_err",  64'(Error),     64'd1);

        // Seal together with a handshake
        set_req(M_ADD, 5'd8, 5'd9, 5'd10, 5'd0, 16'd0);
        SealReq = 1'b1;
        tick();
        InValid = 1'b0;
        SealReq = 1'b0;
        check_eq("simul_addr",  64'(IMemAddr),  64'd4);
        check_eq("simul_data",  64'(IMemWData), 64'h01095020);
        tick();
        check_eq("simul_seal_wr",   64'(IMemWrite), 64'd1);
        check_eq("simul_seal_addr", 64'(IMemAddr),  64'd8);
        check_eq("simul_seal_data", 64'(IMemWData), 64'h08000002);
        check_eq("simul_seal_cnt",  64'(Count),     64'd3);

        // Reset while DONE
        reset = 1'b0;
        tick();
        check_eq("rst2_wr",    64'(IMemWrite), 64'd0);
        check_eq("rst2_count", 64'(Count),     64'd0);
        check_eq("rst2_done",  64'(Done),      64'd0);
        check_eq("rst2_err",   64'(Error),     64'd0);
        check_eq("rst2_addr",  64'(IMemAddr),  64'd0);
        check_eq("rst2_data",  64'(IMemWData), 64'd0);
        reset = 1'b1;
        set_req(M_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5);
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        check_eq("rst2_next_wr",   64'(IMemWrite), 64'd1);
        check_eq("rst2_next_addr", 64'(IMemAddr),  64'd0);

        // Small instance: fill, stall, seal into reserved last word
        do_reset();
        set_req(M_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5);
        InValid = 1'b1;
        tick();
        tick();
        tick();
        check_eq("sm_addr3",  64'(s_IMemAddr), 64'd8);
        check_eq("sm_count3", 64'(s_Count),    64'd3);
        check_eq("sm_full",   64'(s_Full),     64'd1);
        check_eq("sm_ready",  64'(s_InReady),  64'd0);
        tick();
        check_eq("sm_stall_wr",  64'(s_IMemWrite), 64'd0);
        check_eq("sm_stall_cnt", 64'(s_Count),     64'd3);
        SealReq = 1'b1;
        tick();
        SealReq = 1'b0;
        InValid = 1'b0;
        tick();
        check_eq("sm_seal_wr",   64'(s_IMemWrite), 64'd1);
        check_eq("sm_seal_addr", 64'(s_IMemAddr),  64'hC);
        check_eq("sm_seal_data", 64'(s_IMemWData), 64'h08000003);
        check_eq("sm_seal_cnt",  64'(s_Count),     64'd4);
        check_eq("sm_seal_done", 64'(s_Done),      64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
